// File: rtl/gci_std_display_rect_fill.sv
// Rectangle-fill sequencer: one command (x,y,w,h,colour) -> one write beat per pixel, raster order.
// Latency: accept at cycle 0, setup at cycle 1, first beat at cycle 2, FINISH one cycle after last transfer.
// Backpressure: iIF_BUSY stalls the beat stream (addr/data held); oIF_BUSY refuses commands outside IDLE.
// Optional clipping to the visible area is enabled by defining GCI_STD_DISPLAY_RECT_FILL_CLIP_EN.
module gci_std_display_rect_fill #(
    parameter int unsigned P_AREA_H     = 640,
    parameter int unsigned P_AREA_V     = 480,
    parameter int unsigned P_COORD_N    = 10,
    parameter int unsigned P_MEM_ADDR_N = 23,
    parameter int unsigned P_COLOR_N    = 24,
    parameter int unsigned P_BASE_ADDR  = 0
) (
    input  logic                    iCLOCK,
    input  logic                    iRESET_SYNC,
    input  logic                    iIF_VALID,
    output logic                    oIF_BUSY,
    input  logic [P_COORD_N-1:0]    iIF_X,
    input  logic [P_COORD_N-1:0]    iIF_Y,
    input  logic [P_COORD_N-1:0]    iIF_W,
    input  logic [P_COORD_N-1:0]    iIF_H,
    input  logic [P_COLOR_N-1:0]    iIF_COLOR,
    output logic                    oIF_FINISH,
    output logic                    oIF_VALID,
    input  logic                    iIF_BUSY,
    output logic [P_MEM_ADDR_N-1:0] oIF_ADDR,
    output logic [P_COLOR_N-1:0]    oIF_DATA
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_END   = 2'd3;

    localparam logic [P_MEM_ADDR_N-1:0] AREA_H_A = P_MEM_ADDR_N'(P_AREA_H);
    localparam logic [P_MEM_ADDR_N-1:0] BASE_A   = P_MEM_ADDR_N'(P_BASE_ADDR);
    localparam logic [P_COORD_N-1:0]    ONE_C    = P_COORD_N'(1);

    logic [1:0]              state_q, state_d;
    logic [P_COORD_N-1:0]    x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [P_COORD_N-1:0]    w_eff_q, w_eff_d, h_eff_q, h_eff_d;
    logic [P_COORD_N-1:0]    col_q, col_d, row_q, row_d;
    logic [P_MEM_ADDR_N-1:0] row_base_q, row_base_d, addr_q, addr_d;
    logic [P_COLOR_N-1:0]    data_q, data_d;

    logic [P_COORD_N-1:0]    w_eff_c, h_eff_c;
    logic [P_MEM_ADDR_N-1:0] base_c;

`ifdef GCI_STD_DISPLAY_RECT_FILL_CLIP_EN
    localparam logic [31:0] AREA_H_W = 32'(P_AREA_H);
    localparam logic [31:0] AREA_V_W = 32'(P_AREA_V);
    logic [31:0] room_h_c, room_v_c;

    // Clip the latched size to the room left between origin and the visible edge.
    always_comb begin
        room_h_c = (32'(x_q) >= AREA_H_W) ? 32'd0 : AREA_H_W - 32'(x_q);
        room_v_c = (32'(y_q) >= AREA_V_W) ? 32'd0 : AREA_V_W - 32'(y_q);
        // When the room is the smaller value it is below w/h, so it fits the coord width.
        w_eff_c  = (32'(w_q) < room_h_c) ? w_q : room_h_c[P_COORD_N-1:0];
        h_eff_c  = (32'(h_q) < room_v_c) ? h_q : room_v_c[P_COORD_N-1:0];
    end
`else
    // Unclipped: rows run on into the next frame-buffer row and addresses simply wrap.
    always_comb begin
        w_eff_c = w_q;
        h_eff_c = h_q;
    end
`endif

    // Start address of the first row. The result wraps modulo 2^P_MEM_ADDR_N, and
    // modular multiply/add give the same low bits as the full-width product truncated.
    assign base_c = BASE_A + P_MEM_ADDR_N'(y_q) * AREA_H_A + P_MEM_ADDR_N'(x_q);

    // Next-state logic: command capture, setup, raster walk with stall hold, finish.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        w_eff_d    = w_eff_q;
        h_eff_d    = h_eff_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        data_d     = data_q;
        case (state_q)
            ST_IDLE: begin
                if (iIF_VALID) begin
                    x_d     = iIF_X;
                    y_d     = iIF_Y;
                    w_d     = iIF_W;
                    h_d     = iIF_H;
                    data_d  = iIF_COLOR;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_eff_d    = w_eff_c;
                h_eff_d    = h_eff_c;
                row_base_d = base_c;
                addr_d     = base_c;
                col_d      = '0;
                row_d      = '0;
                state_d    = (w_eff_c == '0 || h_eff_c == '0) ? ST_END : ST_FILL;
            end
            ST_FILL: begin
                if (!iIF_BUSY) begin
                    if (col_q == w_eff_q - ONE_C) begin
                        col_d      = '0;
                        row_d      = row_q + ONE_C;
                        row_base_d = row_base_q + AREA_H_A;
                        addr_d     = row_base_q + AREA_H_A;
                        if (row_q == h_eff_q - ONE_C) begin
                            state_d = ST_END;
                        end
                    end else begin
                        col_d  = col_q + ONE_C;
                        addr_d = addr_q + P_MEM_ADDR_N'(1);
                    end
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any fill in progress.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            w_eff_q    <= '0;
            h_eff_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            w_eff_q    <= w_eff_d;
            h_eff_q    <= h_eff_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign oIF_BUSY   = (state_q != ST_IDLE);
    assign oIF_VALID  = (state_q == ST_FILL);
    assign oIF_FINISH = (state_q == ST_END);
    assign oIF_ADDR   = addr_q;
    assign oIF_DATA   = data_q;

endmodule

// File: tb/tb_gci_std_display_rect_fill.sv
// Bench for gci_std_display_rect_fill on a small 64x48 screen with a non-zero base and 12-bit addresses.
// Directed vector table plus random commands, each checked beat-by-beat against a pixel-list model.
// Stall patterns: none, alternating, random; mid-fill reset and held-valid sequences are hand-written.
module tb_gci_std_display_rect_fill;

    localparam int H    = 64;
    localparam int V    = 48;
    localparam int CN   = 10;
    localparam int AW   = 12;
    localparam int CW   = 24;
    localparam int BASE = 100;

    logic          iCLOCK = 1'b0;
    logic          iRESET_SYNC;
    logic          iIF_VALID;
    logic          oIF_BUSY;
    logic [CN-1:0] iIF_X, iIF_Y, iIF_W, iIF_H;
    logic [CW-1:0] iIF_COLOR;
    logic          oIF_FINISH;
    logic          oIF_VALID;
    logic          iIF_BUSY;
    logic [AW-1:0] oIF_ADDR;
    logic [CW-1:0] oIF_DATA;

    gci_std_display_rect_fill #(
        .P_AREA_H(H), .P_AREA_V(V), .P_COORD_N(CN),
        .P_MEM_ADDR_N(AW), .P_COLOR_N(CW), .P_BASE_ADDR(BASE)
    ) dut (
        .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC),
        .iIF_VALID(iIF_VALID), .oIF_BUSY(oIF_BUSY),
        .iIF_X(iIF_X), .iIF_Y(iIF_Y), .iIF_W(iIF_W), .iIF_H(iIF_H),
        .iIF_COLOR(iIF_COLOR), .oIF_FINISH(oIF_FINISH),
        .oIF_VALID(oIF_VALID), .iIF_BUSY(iIF_BUSY),
        .oIF_ADDR(oIF_ADDR), .oIF_DATA(oIF_DATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_checks = 0;
    int n_err    = 0;
    int exp_q[$];

    typedef struct {
        int          x, y, w, h;
        logic [23:0] color;
        int          stall;
        bit          hold;
        int          exp_nb, exp_fa, exp_la, exp_fc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pixel list: every (row, col) of the effective rectangle, in raster order.
    function automatic void build_exp(input int x, input int y, input int w, input int h);
        int we, he;
        exp_q.delete();
        we = w;
        he = h;
`ifdef GCI_STD_DISPLAY_RECT_FILL_CLIP_EN
        if (x >= H) we = 0; else if (w > H - x) we = H - x;
        if (y >= V) he = 0; else if (h > V - y) he = V - y;
`endif
        for (int r = 0; r < he; r++)
            for (int c = 0; c < we; c++)
                exp_q.push_back((BASE + (y + r) * H + x + c) % (1 << AW));
    endfunction

    // Issue one command at the current (IDLE) cycle and follow it to FINISH.
    // stall: 0 none, 1 alternate (stall on odd cycles), 2 random 25%.
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [23:0] color, input int stall, input bit hold,
                           output int nb, output int fa, output int la, output int fc);
        int cyc;
        int last_x;
        bit done;
        build_exp(x, y, w, h);
        iIF_X     = CN'(x);
        iIF_Y     = CN'(y);
        iIF_W     = CN'(w);
        iIF_H     = CN'(h);
        iIF_COLOR = color;
        iIF_VALID = 1'b1;
        iIF_BUSY  = 1'b0;
        chk("accept_busy", oIF_BUSY, 0);
        @(posedge iCLOCK); #1;
        cyc = 1;
        if (!hold) begin
            iIF_VALID = 1'b0;
            iIF_X     = CN'($urandom);
            iIF_Y     = CN'($urandom);
            iIF_W     = CN'($urandom);
            iIF_H     = CN'($urandom);
            iIF_COLOR = CW'($urandom);
        end
        nb = 0; fa = -1; la = -1; fc = -1; last_x = 1; done = 0;
        while (!done && cyc < 20000) begin
            case (stall)
                1:       iIF_BUSY = cyc[0];
                2:       iIF_BUSY = ($urandom_range(0, 3) == 0);
                default: iIF_BUSY = 1'b0;
            endcase
            chk("busy_active", oIF_BUSY, 1);
            if (cyc == 1) chk("setup_no_valid", oIF_VALID, 0);
            if (oIF_VALID) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    chk("beat_addr", oIF_ADDR, exp_q[0]);
                    chk("beat_data", oIF_DATA, color);
                    if (!iIF_BUSY) begin
                        void'(exp_q.pop_front());
                        if (fa < 0) fa = int'(oIF_ADDR);
                        la = int'(oIF_ADDR);
                        nb++;
                        last_x = cyc;
                    end
                end
            end
            if (oIF_FINISH) begin
                fc = cyc;
                chk("beats_left_at_finish", exp_q.size(), 0);
                chk("finish_latency", fc, last_x + 1);
                done = 1;
            end
            @(posedge iCLOCK); #1;
            cyc++;
        end
        if (!done) chk("finish_timeout", 0, 1);
        iIF_BUSY = 1'b0;
        chk("finish_one_cycle", oIF_FINISH, 0);
        chk("idle_busy", oIF_BUSY, 0);
    endtask

    initial begin
        int nb, fa, la, fc, xfers;

        vecs.push_back('{0, 0, 64, 48, 24'h123456, 0, 0, 3072, 100, 3171, 3074});
        vecs.push_back('{10, 2, 3, 2, 24'hABCDEF, 0, 0, 6, 238, 304, 8});
        vecs.push_back('{10, 2, 3, 2, 24'h00FF00, 1, 0, 6, 238, 304, 13});
`ifdef GCI_STD_DISPLAY_RECT_FILL_CLIP_EN
        vecs.push_back('{62, 47, 5, 4, 24'h111111, 0, 0, 2, 3170, 3171, 4});
        vecs.push_back('{5, 63, 2, 2, 24'h222222, 0, 0, 0, -1, -1, 2});
        vecs.push_back('{60, 0, 10, 1, 24'h333333, 0, 0, 4, 160, 163, 6});
`else
        vecs.push_back('{62, 47, 5, 4, 24'h111111, 0, 0, 20, 3170, 3366, 22});
        vecs.push_back('{5, 63, 2, 2, 24'h222222, 0, 0, 4, 41, 106, 6});
        vecs.push_back('{60, 0, 10, 1, 24'h333333, 0, 0, 10, 160, 169, 12});
`endif
        vecs.push_back('{7, 7, 0, 5, 24'h444444, 0, 0, 0, -1, -1, 2});
        vecs.push_back('{7, 7, 5, 0, 24'h555555, 0, 0, 0, -1, -1, 2});
        vecs.push_back('{1, 1, 2, 1, 24'h666666, 0, 1, 2, 165, 166, 4});
        vecs.push_back('{1, 1, 2, 1, 24'h666666, 0, 0, 2, 165, 166, 4});

        iRESET_SYNC = 1'b1;
        iIF_VALID   = 1'b0;
        iIF_BUSY    = 1'b0;
        iIF_X = '0; iIF_Y = '0; iIF_W = '0; iIF_H = '0; iIF_COLOR = '0;
        repeat (3) @(posedge iCLOCK);
        #1;
        iRESET_SYNC = 1'b0;
        chk("rst_busy", oIF_BUSY, 0);
        chk("rst_valid", oIF_VALID, 0);
        chk("rst_finish", oIF_FINISH, 0);
        chk("rst_addr", oIF_ADDR, 0);
        chk("rst_data", oIF_DATA, 0);

        foreach (vecs[i]) begin
            run_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color,
                    vecs[i].stall, vecs[i].hold, nb, fa, la, fc);
            chk("vec_beats", nb, vecs[i].exp_nb);
            chk("vec_first_addr", fa, vecs[i].exp_fa);
            chk("vec_last_addr", la, vecs[i].exp_la);
            chk("vec_finish_cycle", fc, vecs[i].exp_fc);
        end

        // Reset after 100 transfers of a full clear: outputs return to reset values, no FINISH.
        build_exp(0, 0, H, V);
        iIF_X = '0; iIF_Y = '0; iIF_W = CN'(H); iIF_H = CN'(V);
        iIF_COLOR = 24'h0F0F0F;
        iIF_VALID = 1'b1;
        @(posedge iCLOCK); #1;
        iIF_VALID = 1'b0;
        xfers = 0;
        for (int c = 0; c < 400 && xfers < 100; c++) begin
            iIF_BUSY = ($urandom_range(0, 4) == 0);
            if (oIF_VALID) begin
                chk("pre_rst_addr", oIF_ADDR, exp_q[0]);
                if (!iIF_BUSY) begin
                    void'(exp_q.pop_front());
                    xfers++;
                end
            end
            @(posedge iCLOCK); #1;
        end
        chk("pre_rst_xfers", xfers, 100);
        iIF_BUSY    = 1'b0;
        iRESET_SYNC = 1'b1;
        @(posedge iCLOCK); #1;
        iRESET_SYNC = 1'b0;
        chk("mid_rst_valid", oIF_VALID, 0);
        chk("mid_rst_busy", oIF_BUSY, 0);
        chk("mid_rst_addr", oIF_ADDR, 0);
        chk("mid_rst_data", oIF_DATA, 0);
        chk("mid_rst_finish", oIF_FINISH, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge iCLOCK); #1;
            chk("post_rst_no_finish", oIF_FINISH, 0);
        end
        run_cmd(10, 2, 3, 2, 24'hC0FFEE, 0, 0, nb, fa, la, fc);
        chk("post_rst_beats", nb, 6);
        chk("post_rst_first", fa, 238);

        // Random commands, including off-screen origins and random stalls.
        for (int i = 0; i < 40; i++) begin
            run_cmd($urandom_range(0, 70), $urandom_range(0, 52),
                    $urandom_range(0, 10), $urandom_range(0, 5),
                    CW'($urandom), ($urandom_range(0, 1) == 1) ? 2 : 0, 0,
                    nb, fa, la, fc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/gci_std_display_rect_fill.md
Name: gci_std_display_rect_fill

Overview:
Parametrised rectangle-fill sequencer for the display frame buffer. It accepts one command giving origin (x,y), size (w,h) and a solid colour. It then streams one write beat per pixel to the memory-write interface in raster order, row by row, honouring downstream backpressure. A full-screen clear is the special case x=0, y=0, w=P_AREA_H, h=P_AREA_V. It sits between the display command decoder and the frame-buffer write arbiter.

Parameters:
P_AREA_H, 640, visible width in pixels (row pitch of the frame buffer)
P_AREA_V, 480, visible height in pixels
P_COORD_N, 10, width of the x/y/w/h command fields
P_MEM_ADDR_N, 23, pixel address width
P_COLOR_N, 24, pixel data width
P_BASE_ADDR, 0, frame-buffer base pixel address added to every output address

Ports:
iCLOCK  in  1  clock
iRESET_SYNC  in  1  synchronous active-high reset
iIF_VALID  in  1  command valid
oIF_BUSY  out  1  command not accepted; high in every state except IDLE
iIF_X  in  P_COORD_N  origin column
iIF_Y  in  P_COORD_N  origin row
iIF_W  in  P_COORD_N  width in pixels
iIF_H  in  P_COORD_N  height in pixels
iIF_COLOR  in  P_COLOR_N  fill colour
oIF_FINISH  out  1  one-cycle pulse when a command completes
oIF_VALID  out  1  write beat valid
iIF_BUSY  in  1  downstream stall
oIF_ADDR  out  P_MEM_ADDR_N  pixel write address
oIF_DATA  out  P_COLOR_N  pixel write data

Behaviour:
- Clock and reset: one clock, iCLOCK. Reset is synchronous and active-high, iRESET_SYNC. There is no asynchronous reset.
- Reset values: state IDLE, oIF_BUSY=0, oIF_FINISH=0, oIF_VALID=0, oIF_ADDR=0, oIF_DATA=0, all counters 0.
- States: IDLE, SETUP, FILL, END.
- IDLE:
  - Command accepted when iIF_VALID=1 (oIF_BUSY=0).
  - On acceptance, latch x, y, w, h and colour, then go to SETUP.
- SETUP (exactly 1 cycle):
  - Compute effective size: w_eff=min(w, P_AREA_H-x), h_eff=min(h, P_AREA_V-y). See the clip feature.
  - Compute row_base = P_BASE_ADDR + y*P_AREA_H + x.
  - If w_eff=0 or h_eff=0, go to END. Otherwise go to FILL.
- FILL:
  - oIF_VALID=1 in every FILL cycle; it is registered and does not depend combinationally on iIF_BUSY.
  - oIF_ADDR = row_base + col. oIF_DATA = latched colour.
  - A beat transfers when oIF_VALID=1 and iIF_BUSY=0. On transfer, col increments.
  - When col = w_eff-1 transfers: col goes to 0, row increments, row_base += P_AREA_H.
  - After the beat with row=h_eff-1 and col=w_eff-1 transfers, go to END. No extra beat is issued.
  - While iIF_BUSY=1, oIF_ADDR and oIF_DATA are held stable.
- END: oIF_FINISH=1 for one cycle, then IDLE. A new command can be accepted on the following cycle.
- Latency:
  - Accept at cycle 0, SETUP at cycle 1, first oIF_VALID at cycle 2.
  - With no stall, beat n is presented at cycle 2+n. FINISH follows the last transfer by 1 cycle.
- Address arithmetic:
  - Computed at P_MEM_ADDR_N bits and wraps modulo 2^P_MEM_ADDR_N.
  - Internal products are computed at full width before truncation.
- Command inputs are sampled only on acceptance; changes at other times are ignored.
- iRESET_SYNC asserted mid-command:
  - Next cycle returns to IDLE with all outputs at reset values.
  - No FINISH pulse; the partial fill is abandoned.
- iIF_VALID held high during a fill: ignored until IDLE. It is then accepted as a new command.

Optional Feature:
Macro GCI_STD_DISPLAY_RECT_FILL_CLIP_EN.
- Defined:
  - The rectangle is clipped to the visible area as described in SETUP.
  - x>=P_AREA_H or y>=P_AREA_V gives an empty fill: FINISH only, no beats.
- Undefined:
  - No clipping: w_eff=w, h_eff=h.
  - Rows wrap into the following frame-buffer row, and addresses wrap modulo 2^P_MEM_ADDR_N.
  - w=0 or h=0 still gives an empty fill with FINISH only.
  - Saves the comparators and subtractors.

Test Plan:
- Full-screen clear, no stall (cmd 0,0,640,480, colour 0x123456) -> 307200 beats, addr 0..307199 consecutive, data 0x123456, one FINISH pulse at cycle 307202.
- Small rect (x=10, y=2, w=3, h=2) -> addr 1290, 1291, 1292, 1930, 1931, 1932, then FINISH.
- Same small rect with iIF_BUSY toggling every other cycle -> same 6 addresses in order; addr and data held during stall cycles; no duplicated or dropped beat.
- With CLIP_EN, cmd x=638, y=479, w=5, h=4 -> exactly 2 beats, addr 307198 and 307199.
- Without CLIP_EN, the same cmd -> 20 beats; the first row is 307198..307202.
- cmd w=0 -> no oIF_VALID; FINISH at cycle 2 after accept; oIF_BUSY high for cycles 1-2.
- iRESET_SYNC pulsed after 100 beats of a full clear -> next cycle oIF_VALID=0, oIF_BUSY=0, oIF_ADDR=0, no FINISH; a new command is accepted normally afterwards.
